// File: rtl/dfi_phy_handshake_if.sv
// DFI control-interface signal bundle.
// master: memory-controller side; slave: PHY-side handshake engine.
interface dfi_phy_handshake_if;
    logic       init_start;
    logic       init_complete;
    logic       lp_ctrl_req;
    logic [5:0] lp_ctrl_wakeup;
    logic       lp_ctrl_ack;
    logic       lp_data_req;
    logic [5:0] lp_data_wakeup;
    logic       lp_data_ack;
    logic       ctrlupd_req;
    logic       ctrlupd_ack;
    logic       phyupd_req;
    logic [1:0] phyupd_type;
    logic       phyupd_ack;
    logic       phymstr_req;
    logic [1:0] phymstr_type;
    logic [1:0] phymstr_cs_state;
    logic       phymstr_state_sel;
    logic       phymstr_ack;

    modport master (
        output init_start, lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
               ctrlupd_req, phyupd_ack, phymstr_ack,
        input  init_complete, lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req,
               phyupd_type, phymstr_req, phymstr_type, phymstr_cs_state, phymstr_state_sel
    );

    modport slave (
        input  init_start, lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
               ctrlupd_req, phyupd_ack, phymstr_ack,
        output init_complete, lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req,
               phyupd_type, phymstr_req, phymstr_type, phymstr_cs_state, phymstr_state_sel
    );
endinterface

// File: rtl/dfi_phy_handshake.sv
// PHY-side DFI control handshake engine: answers MC low-power, ctrlupd and init
// requests and originates phyupd/phymstr requests with mutual exclusion.
// Optional build macro PROTOCOL_CHECK_EN enables the sticky protocol_err checker;
// without it protocol_err is tied low.

// Low-power handshake FSM (shared by the ctrl and data channels).
module dfi_lp_fsm #(
    parameter int unsigned LP_ACK_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [5:0] wakeup,
    input  logic       deny,
    input  logic       ready,
    output logic       ack,
    output logic [5:0] wakeup_q
);
    typedef enum logic [1:0] {LP_IDLE, LP_WAIT, LP_ACK} lp_state_t;

    localparam int unsigned     CW        = $clog2(LP_ACK_LAT + 2);
    localparam logic [CW-1:0]   WAIT_LAST = CW'(LP_ACK_LAT - 1);

    lp_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State and latency-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LP_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: enter only when allowed, abandon on req drop or init
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LP_IDLE: begin
                cnt_d = CW'(1);
                if (req && !deny && ready) state_d = LP_WAIT;
            end
            LP_WAIT: begin
                if (!req || !ready)         state_d = LP_IDLE;
                else if (cnt_q >= WAIT_LAST) state_d = LP_ACK;
                else                         cnt_d = cnt_q + CW'(1);
            end
            LP_ACK: begin
                if (!req || !ready) state_d = LP_IDLE;
            end
            default: state_d = LP_IDLE;
        endcase
    end

    // Wakeup value captured on the edge that raises ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         wakeup_q <= '0;
        else if (state_d == LP_ACK && state_q != LP_ACK) wakeup_q <= wakeup;
    end

    assign ack = (state_q == LP_ACK);
endmodule

// PHY-originated request FSM (phyupd / phymstr) with pending flag and payload latch.
module dfi_phy_req_fsm #(
    parameter int unsigned PW       = 2,
    parameter int unsigned UPD_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [PW-1:0] payload_in,
    input  logic          launch_ok,
    input  logic          ack,
    output logic          req,
    output logic [PW-1:0] payload,
    output logic          pend,
    output logic          idle,
    output logic          waiting,
    output logic          launch
);
    typedef enum logic [1:0] {REQ_IDLE, REQ_WAIT, REQ_HOLD} req_state_t;

    localparam int unsigned   HW        = $clog2(UPD_HOLD + 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(UPD_HOLD);

    req_state_t    state_q, state_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic          pend_q;
    logic [PW-1:0] pend_pl_q;
    logic [PW-1:0] payload_q;

    assign launch = pend_q && (state_q == REQ_IDLE) && launch_ok;

    // State and hold-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= REQ_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: launch, wait for ack, then hold req for UPD_HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            REQ_IDLE: begin
                cnt_d = HW'(1);
                if (launch) state_d = REQ_WAIT;
            end
            REQ_WAIT: begin
                cnt_d = HW'(1);
                if (ack) state_d = REQ_HOLD;
            end
            REQ_HOLD: begin
                if (cnt_q >= HOLD_LAST) state_d = REQ_IDLE;
                else                    cnt_d = cnt_q + HW'(1);
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    // Pending flag: a trigger always re-arms it (single-deep, newest payload wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_pl_q <= '0;
        end else if (trig) begin
            pend_q    <= 1'b1;
            pend_pl_q <= payload_in;
        end else if (launch) begin
            pend_q    <= 1'b0;
        end
    end

    // Output payload frozen for the whole request, cleared once req drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                             payload_q <= '0;
        else if (launch)                                     payload_q <= pend_pl_q;
        else if (state_q == REQ_HOLD && state_d == REQ_IDLE) payload_q <= '0;
    end

    assign req     = (state_q != REQ_IDLE);
    assign payload = payload_q;
    assign pend    = pend_q;
    assign idle    = (state_q == REQ_IDLE);
    assign waiting = (state_q == REQ_WAIT);
endmodule

// Top level.
module dfi_phy_handshake #(
    parameter int unsigned INIT_LAT     = 4,
    parameter int unsigned LP_ACK_LAT   = 2,
    parameter int unsigned TPHYUPD_RESP = 16,
    parameter int unsigned UPD_HOLD     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dfi_phy_handshake_if.slave    dfi,
    input  logic                  lp_deny,
    input  logic                  upd_trig,
    input  logic [1:0]            upd_type_in,
    input  logic                  mstr_trig,
    input  logic [1:0]            mstr_type_in,
    input  logic [1:0]            mstr_cs_in,
    output logic                  protocol_err
);
    localparam int unsigned   IW        = $clog2(INIT_LAT + 2);
    localparam logic [IW-1:0] INIT_FULL = IW'(INIT_LAT);
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LAT - 1);

    logic [IW-1:0] init_cnt_q;
    logic          init_complete_q;
    logic          ready;
    logic          ctrl_q;
    logic          lp_ctrl_ack, lp_data_ack;
    logic [5:0]    lp_ctrl_wakeup_q, lp_data_wakeup_q;
    logic          unused_wakeup;
    logic          upd_req, upd_pend, upd_idle, upd_waiting, upd_launch, upd_ok;
    logic [1:0]    upd_payload;
    logic          mstr_req, mstr_pend, mstr_idle, mstr_waiting, mstr_launch, mstr_ok;
    logic [3:0]    mstr_payload;

    // Init: drop complete while init_start is high, raise INIT_LAT cycles after it falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q      <= '0;
            init_complete_q <= 1'b0;
        end else if (dfi.init_start) begin
            init_cnt_q      <= '0;
            init_complete_q <= 1'b0;
        end else begin
            if (init_cnt_q != INIT_FULL) init_cnt_q <= init_cnt_q + IW'(1);
            init_complete_q <= (init_cnt_q >= INIT_LAST);
        end
    end

    assign ready = init_complete_q && !dfi.init_start;

    dfi_lp_fsm #(.LP_ACK_LAT(LP_ACK_LAT)) u_lp_ctrl (
        .clk      (clk),
        .rst      (rst),
        .req      (dfi.lp_ctrl_req),
        .wakeup   (dfi.lp_ctrl_wakeup),
        .deny     (lp_deny),
        .ready    (ready),
        .ack      (lp_ctrl_ack),
        .wakeup_q (lp_ctrl_wakeup_q)
    );

    dfi_lp_fsm #(.LP_ACK_LAT(LP_ACK_LAT)) u_lp_data (
        .clk      (clk),
        .rst      (rst),
        .req      (dfi.lp_data_req),
        .wakeup   (dfi.lp_data_wakeup),
        .deny     (lp_deny),
        .ready    (ready),
        .ack      (lp_data_ack),
        .wakeup_q (lp_data_wakeup_q)
    );

    // Latched wakeup codes feed PHY power sequencing outside this block
    assign unused_wakeup = ^{lp_ctrl_wakeup_q, lp_data_wakeup_q};

    // Arbitration: phyupd beats phymstr; neither launches over a ctrlupd grant or init
    assign upd_ok  = mstr_idle && !ctrl_q && !dfi.init_start;
    assign mstr_ok = upd_idle && !upd_pend && !ctrl_q && !dfi.init_start;

    dfi_phy_req_fsm #(.PW(2), .UPD_HOLD(UPD_HOLD)) u_phyupd (
        .clk        (clk),
        .rst        (rst),
        .trig       (upd_trig),
        .payload_in (upd_type_in),
        .launch_ok  (upd_ok),
        .ack        (dfi.phyupd_ack),
        .req        (upd_req),
        .payload    (upd_payload),
        .pend       (upd_pend),
        .idle       (upd_idle),
        .waiting    (upd_waiting),
        .launch     (upd_launch)
    );

    dfi_phy_req_fsm #(.PW(4), .UPD_HOLD(UPD_HOLD)) u_phymstr (
        .clk        (clk),
        .rst        (rst),
        .trig       (mstr_trig),
        .payload_in ({mstr_cs_in, mstr_type_in}),
        .launch_ok  (mstr_ok),
        .ack        (dfi.phymstr_ack),
        .req        (mstr_req),
        .payload    (mstr_payload),
        .pend       (mstr_pend),
        .idle       (mstr_idle),
        .waiting    (mstr_waiting),
        .launch     (mstr_launch)
    );

    // ctrlupd grant: new grant also yields to a PHY request launching this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl_q <= 1'b0;
        else     ctrl_q <= dfi.ctrlupd_req && !dfi.init_start &&
                           (ctrl_q || (!upd_req && !mstr_req && !upd_launch && !mstr_launch));
    end

    assign dfi.init_complete     = init_complete_q;
    assign dfi.lp_ctrl_ack       = lp_ctrl_ack;
    assign dfi.lp_data_ack       = lp_data_ack;
    assign dfi.ctrlupd_ack       = ctrl_q && dfi.ctrlupd_req;
    assign dfi.phyupd_req        = upd_req;
    assign dfi.phyupd_type       = upd_payload;
    assign dfi.phymstr_req       = mstr_req;
    assign dfi.phymstr_type      = mstr_payload[1:0];
    assign dfi.phymstr_cs_state  = mstr_payload[3:2];
    assign dfi.phymstr_state_sel = (mstr_payload[3:2] != 2'b00);

`ifdef PROTOCOL_CHECK_EN
    localparam int unsigned   TW      = $clog2(TPHYUPD_RESP + 2);
    localparam logic [TW-1:0] TO_LAST = TW'(TPHYUPD_RESP - 1);
    localparam logic [TW-1:0] TO_FULL = TW'(TPHYUPD_RESP);

    logic          err_q;
    logic          upd_req_prev_q;
    logic [TW-1:0] to_cnt_q;
    logic          unacked;
    logic          err_now;

    assign unacked = (upd_waiting && !dfi.phyupd_ack) || (mstr_waiting && !dfi.phymstr_ack);
    assign err_now = (unacked && (to_cnt_q >= TO_LAST))
                  || (dfi.phyupd_ack && dfi.phymstr_ack)
                  || (dfi.phyupd_ack && !upd_req_prev_q)
                  || (dfi.init_start && (dfi.lp_ctrl_req || dfi.lp_data_req || dfi.ctrlupd_req));

    // Sticky protocol checker with ack-timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q          <= 1'b0;
            upd_req_prev_q <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            upd_req_prev_q <= upd_req;
            if (!unacked)              to_cnt_q <= '0;
            else if (to_cnt_q != TO_FULL) to_cnt_q <= to_cnt_q + TW'(1);
            if (err_now) err_q <= 1'b1;
        end
    end

    assign protocol_err = err_q;
`else
    logic unused_check;
    assign unused_check = ^{upd_waiting, mstr_waiting, 32'(TPHYUPD_RESP)};
    assign protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_dfi_phy_handshake.sv
// Directed self-checking bench for dfi_phy_handshake.
module tb_dfi_phy_handshake;
    logic       clk;
    logic       rst;
    logic       lp_deny;
    logic       upd_trig;
    logic [1:0] upd_type_in;
    logic       mstr_trig;
    logic [1:0] mstr_type_in;
    logic [1:0] mstr_cs_in;
    logic       protocol_err;
    int         pass_cnt;
    int         total_cnt;

    dfi_phy_handshake_if dfi ();

    dfi_phy_handshake #(
        .INIT_LAT     (4),
        .LP_ACK_LAT   (2),
        .TPHYUPD_RESP (16),
        .UPD_HOLD     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dfi          (dfi.slave),
        .lp_deny      (lp_deny),
        .upd_trig     (upd_trig),
        .upd_type_in  (upd_type_in),
        .mstr_trig    (mstr_trig),
        .mstr_type_in (mstr_type_in),
        .mstr_cs_in   (mstr_cs_in),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reinit;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        rst = 1'b1;
        dfi.init_start = 1'b0; dfi.lp_ctrl_req = 1'b0; dfi.lp_ctrl_wakeup = '0;
        dfi.lp_data_req = 1'b0; dfi.lp_data_wakeup = '0; dfi.ctrlupd_req = 1'b0;
        dfi.phyupd_ack = 1'b0; dfi.phymstr_ack = 1'b0;
        lp_deny = 1'b0; upd_trig = 1'b0; upd_type_in = '0;
        mstr_trig = 1'b0; mstr_type_in = '0; mstr_cs_in = '0;
        repeat (2) tick();
        outs = {dfi.init_complete, dfi.lp_ctrl_ack, dfi.lp_data_ack, dfi.ctrlupd_ack,
                dfi.phyupd_req, dfi.phyupd_type, dfi.phymstr_req, dfi.phymstr_type,
                dfi.phymstr_cs_state, dfi.phymstr_state_sel, protocol_err};
        total_cnt++;
        if (outs !== 14'd0) $display("FAIL reset_outputs: got %b want %b", outs, 14'd0);
        else pass_cnt++;
        rst = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (dfi.init_complete !== 1'b0) $display("FAIL reset_init_cycle3: got %b want 0", dfi.init_complete);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dfi.init_complete !== 1'b1) $display("FAIL reset_init_cycle4: got %b want 1", dfi.init_complete);
        else pass_cnt++;
    endtask

    task automatic test_init_pulse;
        dfi.init_start = 1'b1;
        tick();
        total_cnt++;
        if (dfi.init_complete !== 1'b0) $display("FAIL init_drop: got %b want 0", dfi.init_complete);
        else pass_cnt++;
        repeat (2) tick();
        dfi.init_start = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (dfi.init_complete !== 1'b0) $display("FAIL init_still_low: got %b want 0", dfi.init_complete);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dfi.init_complete !== 1'b1) $display("FAIL init_rise: got %b want 1", dfi.init_complete);
        else pass_cnt++;
    endtask

    task automatic test_lp;
        logic ack, other;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin dfi.lp_ctrl_req = 1'b1; dfi.lp_ctrl_wakeup = 6'h2A; end
            else        begin dfi.lp_data_req = 1'b1; dfi.lp_data_wakeup = 6'h15; end
            tick();
            ack = (s == 0) ? dfi.lp_ctrl_ack : dfi.lp_data_ack;
            total_cnt++;
            if (ack !== 1'b0) $display("FAIL lp_wait_s%0d: got %b want 0", s, ack);
            else pass_cnt++;
            tick();
            ack   = (s == 0) ? dfi.lp_ctrl_ack : dfi.lp_data_ack;
            other = (s == 0) ? dfi.lp_data_ack : dfi.lp_ctrl_ack;
            total_cnt++;
            if (ack !== 1'b1) $display("FAIL lp_ack_rise_s%0d: got %b want 1", s, ack);
            else pass_cnt++;
            total_cnt++;
            if (other !== 1'b0) $display("FAIL lp_other_idle_s%0d: got %b want 0", s, other);
            else pass_cnt++;
            repeat (6) tick();
            ack = (s == 0) ? dfi.lp_ctrl_ack : dfi.lp_data_ack;
            total_cnt++;
            if (ack !== 1'b1) $display("FAIL lp_ack_hold_s%0d: got %b want 1", s, ack);
            else pass_cnt++;
            if (s == 0) dfi.lp_ctrl_req = 1'b0; else dfi.lp_data_req = 1'b0;
            tick();
            ack = (s == 0) ? dfi.lp_ctrl_ack : dfi.lp_data_ack;
            total_cnt++;
            if (ack !== 1'b0) $display("FAIL lp_ack_fall_s%0d: got %b want 0", s, ack);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_lp_deny;
        lp_deny = 1'b1;
        dfi.lp_ctrl_req = 1'b1;
        repeat (8) tick();
        total_cnt++;
        if (dfi.lp_ctrl_ack !== 1'b0) $display("FAIL lp_deny: got %b want 0", dfi.lp_ctrl_ack);
        else pass_cnt++;
        dfi.lp_ctrl_req = 1'b0;
        lp_deny = 1'b0;
        tick();
        // req withdrawn while waiting: no ack may follow
        dfi.lp_data_req = 1'b1;
        tick();
        dfi.lp_data_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (dfi.lp_data_ack !== 1'b0) $display("FAIL lp_abort_%0d: got %b want 0", k, dfi.lp_data_ack);
            else pass_cnt++;
        end
    endtask

    task automatic test_ctrlupd;
        dfi.ctrlupd_req = 1'b1;
        #1;
        total_cnt++;
        if (dfi.ctrlupd_ack !== 1'b0) $display("FAIL ctrlupd_c1: got %b want 0", dfi.ctrlupd_ack);
        else pass_cnt++;
        for (int c = 2; c <= 5; c++) begin
            tick();
            total_cnt++;
            if (dfi.ctrlupd_ack !== 1'b1) $display("FAIL ctrlupd_c%0d: got %b want 1", c, dfi.ctrlupd_ack);
            else pass_cnt++;
        end
        tick();
        dfi.ctrlupd_req = 1'b0;
        #1;
        total_cnt++;
        if (dfi.ctrlupd_ack !== 1'b0) $display("FAIL ctrlupd_fall: got %b want 0", dfi.ctrlupd_ack);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_phyupd;
        upd_type_in = 2'b01;
        upd_trig = 1'b1;
        tick();
        upd_trig = 1'b0;
        tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phyupd_type} !== 3'b101)
            $display("FAIL upd_launch: got %b want %b", {dfi.phyupd_req, dfi.phyupd_type}, 3'b101);
        else pass_cnt++;
        tick();
        // re-arm while busy with a different type
        upd_type_in = 2'b11;
        upd_trig = 1'b1;
        tick();
        upd_trig = 1'b0;
        total_cnt++;
        if (dfi.phyupd_type !== 2'b01) $display("FAIL upd_type_stable: got %b want 01", dfi.phyupd_type);
        else pass_cnt++;
        tick();
        dfi.phyupd_ack = 1'b1;
        tick();
        dfi.phyupd_ack = 1'b0;
        repeat (7) tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phyupd_type, dfi.phymstr_req} !== 4'b1010)
            $display("FAIL upd_hold: got %b want %b", {dfi.phyupd_req, dfi.phyupd_type, dfi.phymstr_req}, 4'b1010);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (dfi.phyupd_req !== 1'b0) $display("FAIL upd_drop: got %b want 0", dfi.phyupd_req);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phyupd_type} !== 3'b111)
            $display("FAIL upd_rearm: got %b want %b", {dfi.phyupd_req, dfi.phyupd_type}, 3'b111);
        else pass_cnt++;
        dfi.phyupd_ack = 1'b1;
        tick();
        dfi.phyupd_ack = 1'b0;
        repeat (8) tick();
        total_cnt++;
        if ({dfi.phyupd_req, protocol_err} !== 2'b00)
            $display("FAIL upd_rearm_done: got %b want 00", {dfi.phyupd_req, protocol_err});
        else pass_cnt++;
    endtask

    task automatic test_arbitration;
        upd_type_in = 2'b10;
        mstr_type_in = 2'b11;
        mstr_cs_in = 2'b01;
        upd_trig = 1'b1;
        mstr_trig = 1'b1;
        tick();
        upd_trig = 1'b0;
        mstr_trig = 1'b0;
        tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phymstr_req} !== 2'b10)
            $display("FAIL arb_upd_first: got %b want 10", {dfi.phyupd_req, dfi.phymstr_req});
        else pass_cnt++;
        dfi.ctrlupd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            #1;
            total_cnt++;
            if (dfi.ctrlupd_ack !== 1'b0) $display("FAIL arb_ctrlupd_blocked_%0d: got %b want 0", k, dfi.ctrlupd_ack);
            else pass_cnt++;
        end
        dfi.phyupd_ack = 1'b1;
        tick();
        dfi.phyupd_ack = 1'b0;
        dfi.ctrlupd_req = 1'b0;
        repeat (7) tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phymstr_req} !== 2'b10)
            $display("FAIL arb_upd_hold: got %b want 10", {dfi.phyupd_req, dfi.phymstr_req});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dfi.phyupd_req, dfi.phymstr_req} !== 2'b00)
            $display("FAIL arb_gap: got %b want 00", {dfi.phyupd_req, dfi.phymstr_req});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({dfi.phymstr_req, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel} !== 6'b111011)
            $display("FAIL arb_mstr_launch: got %b want %b",
                     {dfi.phymstr_req, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel}, 6'b111011);
        else pass_cnt++;
        dfi.phymstr_ack = 1'b1;
        tick();
        dfi.phymstr_ack = 1'b0;
        repeat (8) tick();
        total_cnt++;
        if ({dfi.phymstr_req, dfi.phymstr_state_sel, protocol_err} !== 3'b000)
            $display("FAIL arb_mstr_done: got %b want 000", {dfi.phymstr_req, dfi.phymstr_state_sel, protocol_err});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        mstr_type_in = 2'b01;
        mstr_cs_in = 2'b00;
        mstr_trig = 1'b1;
        tick();
        mstr_trig = 1'b0;
        tick();
        total_cnt++;
        if ({dfi.phymstr_req, dfi.phymstr_type, dfi.phymstr_state_sel} !== 4'b1010)
            $display("FAIL mstr_sel0: got %b want 1010", {dfi.phymstr_req, dfi.phymstr_type, dfi.phymstr_state_sel});
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({dfi.phymstr_req, dfi.phymstr_type, dfi.init_complete} !== 4'b0000)
            $display("FAIL reset_mid: got %b want 0000", {dfi.phymstr_req, dfi.phymstr_type, dfi.init_complete});
        else pass_cnt++;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_protocol;
        upd_type_in = 2'b00;
        upd_trig = 1'b1;
        tick();
        upd_trig = 1'b0;
        tick();
`ifdef PROTOCOL_CHECK_EN
        repeat (15) tick();
        total_cnt++;
        if (protocol_err !== 1'b0) $display("FAIL err_before_timeout: got %b want 0", protocol_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (protocol_err !== 1'b1) $display("FAIL err_timeout: got %b want 1", protocol_err);
        else pass_cnt++;
        dfi.phyupd_ack = 1'b1;
        tick();
        dfi.phyupd_ack = 1'b0;
        repeat (12) tick();
        total_cnt++;
        if (protocol_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", protocol_err);
        else pass_cnt++;
`else
        repeat (20) tick();
        total_cnt++;
        if (protocol_err !== 1'b0) $display("FAIL err_tied_low: got %b want 0", protocol_err);
        else pass_cnt++;
`endif
        reinit();
        total_cnt++;
        if ({protocol_err, dfi.phyupd_req, dfi.init_complete} !== 3'b001)
            $display("FAIL err_after_reset: got %b want 001", {protocol_err, dfi.phyupd_req, dfi.init_complete});
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_init_pulse();
        test_lp();
        test_lp_deny();
        test_ctrlupd();
        test_phyupd();
        test_arbitration();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dfi_phy_handshake.md
Name: dfi_phy_handshake

Overview:
- PHY-side DFI control-interface handshake engine. It answers MC-initiated requests (low-power ctrl/data, ctrlupd, init) and originates PHY-initiated requests (phyupd, phymstr).
- Sits between the DFI control pins and PHY-internal trigger logic.
- Guarantees the DFI ordering and mutual-exclusion rules: no phyupd_ack with phymstr_ack, no ctrlupd concurrent with phyupd, and init_start blocks every other handshake.

Parameters:
- INIT_LAT, 4, cycles from init_start low (or reset release) to init_complete high.
- LP_ACK_LAT, 2, cycles from lp_*_req rise to lp_*_ack.
- TPHYUPD_RESP, 16, max cycles phyupd_req/phymstr_req may wait for ack before error.
- UPD_HOLD, 8, cycles req stays high after ack seen.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- init_start  in  1  MC init/frequency-change request.
- init_complete  out  1  PHY ready.
- lp_ctrl_req  in  1; lp_ctrl_wakeup  in  6; lp_ctrl_ack  out  1.
- lp_data_req  in  1; lp_data_wakeup  in  6; lp_data_ack  out  1.
- lp_deny  in  1  PHY refuses low-power entry.
- ctrlupd_req  in  1; ctrlupd_ack  out  1.
- phyupd_req  out  1; phyupd_type  out  2; phyupd_ack  in  1.
- phymstr_req  out  1; phymstr_type  out  2; phymstr_cs_state  out  2; phymstr_state_sel  out  1; phymstr_ack  in  1.
- upd_trig  in  1  pulse requesting phyupd; upd_type_in  in  2.
- mstr_trig  in  1  pulse requesting phymstr; mstr_type_in  in  2; mstr_cs_in  in  2.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0. Pending flags cleared. Reset mid-handshake drops every req/ack immediately.
- Init:
  - init_complete goes 0 the cycle after init_start is sampled high.
  - It rises INIT_LAT cycles after init_start is sampled low (also after reset release with init_start low).
  - While init_start=1: no new phyupd/phymstr request launches, and lp/ctrlupd acks are held 0.
- LP ctrl and LP data are independent, identical FSMs: IDLE -> WAIT (req high, lp_deny=0, init_complete=1) -> ACK after LP_ACK_LAT cycles.
  - ack is registered, and stays high while req is high.
  - req low -> ack low on the next cycle -> IDLE.
  - If req falls during WAIT -> IDLE with no ack.
  - lp_deny=1 keeps the FSM in IDLE (the MC times out by itself).
  - The wakeup value is latched at ack rise; it is internal only.
- ctrlupd:
  - Registered grant ctrl_q set 1 cycle after req is sampled high, only if phyupd_req=0, phymstr_req=0 and init_start=0.
  - ctrlupd_ack = ctrl_q AND ctrlupd_req (combinational gate), so ack is never high without req.
  - ctrl_q clears when req is low.
- phyupd:
  - upd_trig sets a pending flag and latches type.
  - Launch when no ctrl_q, no phymstr activity and init_start=0: phyupd_req=1, phyupd_type=latched.
  - Hold until phyupd_ack is sampled, then hold UPD_HOLD more cycles, then drop req. Type stays stable while req=1.
  - Triggers arriving while busy re-arm pending; they are not queued further.
- phymstr: same FSM as phyupd, with type/cs_state latched.
  - phymstr_state_sel = 1 when mstr_cs_in != 0.
- Arbitration: simultaneous pending phyupd and phymstr -> phyupd first. At most one of {phyupd_req, phymstr_req, ctrl_q} is active at any time.

Optional Feature:
- PROTOCOL_CHECK_EN defined: protocol_err sets (sticky until reset) on any of:
  - phyupd_req or phymstr_req high TPHYUPD_RESP cycles without ack.
  - phyupd_ack AND phymstr_ack high together.
  - phyupd_ack while phyupd_req was low the previous cycle.
  - init_start high while lp_*_req or ctrlupd_req is high.
- Undefined: protocol_err tied 0, no checker logic.

Test Plan:
- Reset released, init_start=0 -> init_complete=1 at cycle 4. Pulse init_start 3 cycles -> init_complete low the next cycle, high 4 cycles after init_start falls.
- lp_ctrl_req rises at cycle 10 -> lp_ctrl_ack=1 at cycle 12. req falls at cycle 20 -> ack=0 at cycle 21. lp_deny=1 -> ack stays 0 indefinitely.
- ctrlupd_req held 5 cycles -> ack high cycles 2-5 relative to req rise; ack falls the same cycle req falls.
- upd_trig, type=2'b01 -> phyupd_req=1, type=01. Ack after 3 cycles -> req drops 8 cycles after ack; protocol_err=0.
- upd_trig and mstr_trig in the same cycle -> phyupd completes first, phymstr_req rises only after phyupd_req falls. ctrlupd_req during phyupd -> ctrlupd_ack stays 0.
- PROTOCOL_CHECK_EN: no phyupd_ack for 16 cycles -> protocol_err=1, held until reset.
